// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the MIPS-subset CPU control path:
//   - FSM state encodings of the multi-cycle sequencer
//   - opcode / R-type function constants
//   - ALU function codes driven on alu_op
//   - datapath mux select encodings (reg_dst, wb_sel, alu_src_a/b, pc_src)
//   - instruction classes plus a helper that classifies a decoded instruction
// -----------------------------------------------------------------------------
package cpu_defs_pkg;

  // FSM states; the encoding is visible on the state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FUNC_SLL     = 6'd0;
  localparam logic [5:0] FUNC_SRL     = 6'd2;
  localparam logic [5:0] FUNC_SRA     = 6'd3;
  localparam logic [5:0] FUNC_JR      = 6'd8;
  localparam logic [5:0] FUNC_SYSCALL = 6'd12;
  localparam logic [5:0] FUNC_ADD     = 6'd32;
  localparam logic [5:0] FUNC_ADDU    = 6'd33;
  localparam logic [5:0] FUNC_SUB     = 6'd34;
  localparam logic [5:0] FUNC_AND     = 6'd36;
  localparam logic [5:0] FUNC_OR      = 6'd37;
  localparam logic [5:0] FUNC_NOR     = 6'd39;
  localparam logic [5:0] FUNC_SLT     = 6'd42;
  localparam logic [5:0] FUNC_SLTU    = 6'd43;

  // ALU function codes
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  // Register-file destination select
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // Write-back source select
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_SIMM = 2'd2;
  localparam logic [1:0] SRC_B_ZIMM = 2'd3;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // Instruction classes that steer the sequencer.
  typedef enum logic [3:0] {
    IC_RALU,
    IC_IALU,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_BNE,
    IC_JR,
    IC_J,
    IC_JAL,
    IC_SYSCALL,
    IC_ILLEGAL
  } iclass_e;

  // Anything the ALU decoder accepts and that is not listed explicitly here
  // is one of the immediate ALU opcodes.
  function automatic iclass_e classify(input logic [5:0] op_code,
                                       input logic [5:0] func,
                                       input logic       legal);
    iclass_e ic;
    ic = IC_IALU;
    if (!legal) begin
      ic = IC_ILLEGAL;
    end else begin
      case (op_code)
        OP_R: begin
          if (func == FUNC_JR)           ic = IC_JR;
          else if (func == FUNC_SYSCALL) ic = IC_SYSCALL;
          else                           ic = IC_RALU;
        end
        OP_J:    ic = IC_J;
        OP_JAL:  ic = IC_JAL;
        OP_BEQ:  ic = IC_BEQ;
        OP_BNE:  ic = IC_BNE;
        OP_LW:   ic = IC_LW;
        OP_SW:   ic = IC_SW;
        default: ic = IC_IALU;
      endcase
    end
    return ic;
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// -----------------------------------------------------------------------------
// alu_op_dec
// Combinational ALU-function decoder shared by the single- and multi-cycle
// controllers. Maps (op_code, func) to an ALU function code and reports
// whether the encoding belongs to the supported instruction subset.
//   op_code_i [5:0] : IR[31:26]
//   func_i    [5:0] : IR[5:0]
//   alu_op_o  [3:0] : ALU function for the EXEC step of this instruction
//   legal_o         : 1 when the encoding is supported
// -----------------------------------------------------------------------------
module alu_op_dec
  import cpu_defs_pkg::*;
(
  input  logic [5:0] op_code_i,
  input  logic [5:0] func_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    alu_op_o = ALU_SLL;
    legal_o  = 1'b0;
    case (op_code_i)
      OP_R: begin
        legal_o = 1'b1;
        case (func_i)
          FUNC_SLL:              alu_op_o = ALU_SLL;
          FUNC_SRL:              alu_op_o = ALU_SRL;
          FUNC_SRA:              alu_op_o = ALU_SRA;
          FUNC_JR, FUNC_SYSCALL: alu_op_o = ALU_SLL;
          FUNC_ADD, FUNC_ADDU:   alu_op_o = ALU_ADD;
          FUNC_SUB:              alu_op_o = ALU_SUB;
          FUNC_AND:              alu_op_o = ALU_AND;
          FUNC_OR:               alu_op_o = ALU_OR;
          FUNC_NOR:              alu_op_o = ALU_NOR;
          FUNC_SLT:              alu_op_o = ALU_SLT;
          FUNC_SLTU:             alu_op_o = ALU_SLTU;
          default:               legal_o  = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        legal_o = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_ADD;
      end
      OP_SLTI: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_SLT;
      end
      OP_ANDI: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_AND;
      end
      OP_ORI: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_OR;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for the MIPS-subset datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, issues datapath enables, mux selects and
// ALU function, stalls on mem_ready and halts on syscall or illegal encodings.
// Inputs : clk, rst_n (async, active low), op_code/func (IR fields, valid
//          from DECODE on), zero (ALU flag), mem_ready, go (leave HALT).
// Outputs: pc_we, ir_we, mem_rd, mem_wr, iord, rf_we, reg_dst, wb_sel,
//          alu_src_a, alu_src_b, alu_op, pc_src, state, halted, err,
//          cycle_cnt (non-HALT cycles), instr_cnt (retired instructions).
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_code,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             go,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             iord,
  output logic             rf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic             err_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;

  logic             retire;     // instruction leaves its last state this cycle
  logic             set_err;    // illegal encoding detected in DECODE
  logic [3:0]       dec_alu_op;
  logic             dec_legal;
  iclass_e          iclass;
  logic             is_shift;

  alu_op_dec u_alu_op_dec (
    .op_code_i (op_code),
    .func_i    (func),
    .alu_op_o  (dec_alu_op),
    .legal_o   (dec_legal)
  );

  assign iclass   = classify(op_code, func, dec_legal);
  assign is_shift = (func == FUNC_SLL) || (func == FUNC_SRL) || (func == FUNC_SRA);

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      err_q       <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      err_q   <= err_q | set_err;
      if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire)             instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    set_err = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (iclass)
          IC_J: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          IC_JAL: state_d = ST_WB;
          IC_SYSCALL: begin
            state_d = ST_HALT;
            retire  = 1'b1;
          end
          IC_ILLEGAL: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = ST_HALT;
              set_err = 1'b1;
            end else begin
              state_d = ST_FETCH;
              retire  = 1'b1;
            end
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (iclass)
          IC_LW, IC_SW: state_d = ST_MEM;
          IC_BEQ, IC_BNE, IC_JR: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (iclass == IC_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT: begin
        if (go) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: Moore on state and the IR fields, except the mem_ready
  // qualified fetch writes and the zero-qualified branch write.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    iord      = 1'b0;
    rf_we     = 1'b0;
    reg_dst   = REG_DST_RT;
    wb_sel    = WB_ALUOUT;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RT;
    alu_op    = ALU_SLL;
    pc_src    = PC_SRC_ALU;
    halted    = 1'b0;
    // Reset forces FETCH, whose decode would request a read; gating on rst_n
    // keeps every strobe low for the whole reset, including the cycle it
    // arrives in mid-access.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_ADD;
          pc_src    = PC_SRC_ALU;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        ST_DECODE: begin
          // Branch target precomputed while the instruction is decoded.
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_SIMM;
          alu_op    = ALU_ADD;
          if (iclass == IC_J) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_JUMP;
          end
        end
        ST_EXEC: begin
          case (iclass)
            IC_RALU: begin
              alu_src_a = is_shift ? SRC_A_SHAMT : SRC_A_RS;
              alu_src_b = SRC_B_RT;
              alu_op    = dec_alu_op;
            end
            IC_IALU: begin
              alu_src_a = SRC_A_RS;
              alu_src_b = (op_code == OP_ANDI || op_code == OP_ORI) ? SRC_B_ZIMM : SRC_B_SIMM;
              alu_op    = dec_alu_op;
            end
            IC_LW, IC_SW: begin
              alu_src_a = SRC_A_RS;
              alu_src_b = SRC_B_SIMM;
              alu_op    = ALU_ADD;
            end
            IC_BEQ, IC_BNE: begin
              alu_src_a = SRC_A_RS;
              alu_src_b = SRC_B_RT;
              alu_op    = ALU_SUB;
              pc_src    = PC_SRC_BRANCH;
              pc_we     = (iclass == IC_BEQ) ? zero : ~zero;
            end
            IC_JR: begin
              pc_src = PC_SRC_RS;
              pc_we  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          iord   = 1'b1;
          mem_rd = (iclass == IC_LW);
          mem_wr = (iclass != IC_LW);
        end
        ST_WB: begin
          rf_we = 1'b1;
          case (iclass)
            IC_RALU: begin
              reg_dst = REG_DST_RD;
              wb_sel  = WB_ALUOUT;
            end
            IC_LW: begin
              reg_dst = REG_DST_RT;
              wb_sel  = WB_MDR;
            end
            IC_JAL: begin
              reg_dst = REG_DST_RA;
              wb_sel  = WB_PC4;
              pc_we   = 1'b1;
              pc_src  = PC_SRC_JUMP;
            end
            default: begin
              reg_dst = REG_DST_RT;
              wb_sel  = WB_ALUOUT;
            end
          endcase
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule
